// File: rtl/router_pkg.sv
// Shared types and helpers for the router egress scheduler.
// Header byte layout is {len[7:2], addr[1:0]}.
package router_pkg;

    localparam int N_PORTS     = 3;
    localparam int HDR_LEN_W   = 6;
    localparam int HDR_LEN_LSB = 2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } skid_t;

    // Returns {found, port}: first requester after ptr, wrapping mod 3.
    function automatic logic [2:0] rr_pick(
        input logic [1:0]         ptr,
        input logic [N_PORTS-1:0] req
    );
        logic [2:0] res;
        logic [1:0] p;
        res = '0;
        p   = ptr;
        for (int i = 0; i < N_PORTS; i++) begin
            p = (p == 2'd2) ? 2'd0 : p + 2'd1;
            if (req[p] && !res[2]) begin
                res = {1'b1, p};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry {data,last} FIFO that presents the egress byte channel.
// Output data is forced to zero while empty.
module router_skid_buf
    import router_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  skid_t      i_push_d,
    input  logic       i_pop,
    output logic [1:0] o_count,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last
);

    skid_t      r_mem [2];
    logic       r_rd;
    logic       r_wr;
    logic [1:0] r_cnt;
    skid_t      w_head;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_push_d;
                r_wr        <= ~r_wr;
            end
            if (i_pop) begin
                r_rd <= ~r_rd;
            end
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign w_head  = r_mem[r_rd];
    assign o_count = r_cnt;
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = o_valid ? w_head.data : 8'h00;
    assign o_last  = o_valid & w_head.last;

endmodule

// File: rtl/router_out_sched.sv
// Packet-granular round-robin drain of three router FIFOs onto one
// egress byte channel, with stall timeout and per-port FIFO purge.
module router_out_sched
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30,
    parameter int LEN_W   = HDR_LEN_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] fifo_empty,
    input  logic [7:0] fifo_data_0,
    input  logic [7:0] fifo_data_1,
    input  logic [7:0] fifo_data_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic [1:0] out_port,
    output logic       busy
);

    localparam int CNT_W = LEN_W + 1;
    localparam int SC_W  = $clog2(TIMEOUT + 1);

    state_e           r_state;
    logic [1:0]       r_port;
    logic [1:0]       r_ptr;
    logic             r_busy;
    logic             r_hdr_wait;
    logic             r_inflight;
    logic [CNT_W-1:0] r_rd_left;
    logic [CNT_W-1:0] r_ret_left;
    logic [SC_W-1:0]  r_stall;
    logic [2:0]       r_soft;

    logic [7:0]       w_data_sel;
    logic [CNT_W-1:0] w_len1;
    logic [1:0]       w_skid_cnt;
    logic             w_in_xfer;
    logic             w_room;
    logic             w_rd;
    logic             w_fire;
    logic             w_stall;
    logic             w_abort;
    logic             w_done;
    logic             w_push;
    skid_t            w_push_d;
    logic [2:0]       w_pick;

    always_comb begin
        w_data_sel = fifo_data_0;
        case (r_port)
            2'd1:    w_data_sel = fifo_data_1;
            2'd2:    w_data_sel = fifo_data_2;
            default: w_data_sel = fifo_data_0;
        endcase
    end

    assign w_len1    = {1'b0, w_data_sel[HDR_LEN_LSB +: LEN_W]} + CNT_W'(1);
    assign w_in_xfer = (r_state == XFER);
    // Reads in flight reserve skid space so a returning byte always fits.
    assign w_room    = ({1'b0, w_skid_cnt} + {2'b00, r_inflight}) < 3'd2;
    assign w_rd      = w_in_xfer & !fifo_empty[r_port]
                     & (r_rd_left != '0) & w_room;
    assign w_fire    = out_valid & out_ready;
    assign w_stall   = w_in_xfer & out_valid & !out_ready;
    assign w_abort   = w_stall & (r_stall == SC_W'(TIMEOUT - 1));
    assign w_done    = w_in_xfer & w_fire & out_last;
    assign w_push    = w_in_xfer & r_inflight & !w_abort;
    assign w_push_d  = {(!r_hdr_wait && (r_ret_left == CNT_W'(1))),
                        w_data_sel};
    // A port being purged is skipped until its empty flag catches up.
    assign w_pick    = rr_pick(r_ptr, ~fifo_empty & ~r_soft);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_port     <= 2'd0;
            r_ptr      <= 2'd2;
            r_busy     <= 1'b0;
            r_hdr_wait <= 1'b0;
            r_inflight <= 1'b0;
            r_rd_left  <= '0;
            r_ret_left <= '0;
            r_stall    <= '0;
            r_soft     <= '0;
        end else begin
            r_soft <= '0;
            case (r_state)
                IDLE: begin
                    if (w_pick[2]) begin
                        r_port     <= w_pick[1:0];
                        r_rd_left  <= CNT_W'(1);
                        r_ret_left <= '0;
                        r_hdr_wait <= 1'b1;
                        r_inflight <= 1'b0;
                        r_stall    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    r_inflight <= w_rd;
                    if (w_rd) begin
                        r_rd_left <= r_rd_left - CNT_W'(1);
                    end
                    if (w_push) begin
                        if (r_hdr_wait) begin
                            r_hdr_wait <= 1'b0;
                            r_rd_left  <= w_len1;
                            r_ret_left <= w_len1;
                        end else begin
                            r_ret_left <= r_ret_left - CNT_W'(1);
                        end
                    end
                    if (!w_stall) begin
                        r_stall <= '0;
                    end else if (r_stall < SC_W'(TIMEOUT)) begin
                        r_stall <= r_stall + SC_W'(1);
                    end
                    if (w_abort) begin
                        r_soft     <= 3'b001 << r_port;
                        r_ptr      <= r_port;
                        r_busy     <= 1'b0;
                        r_inflight <= 1'b0;
                        r_stall    <= '0;
                        r_state    <= IDLE;
                    end else if (w_done) begin
                        r_ptr   <= r_port;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    router_skid_buf u_skid (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_flush  (w_abort),
        .i_push   (w_push),
        .i_push_d (w_push_d),
        .i_pop    (w_fire),
        .o_count  (w_skid_cnt),
        .o_valid  (out_valid),
        .o_data   (out_data),
        .o_last   (out_last)
    );

    assign read_enb_0   = w_rd & (r_port == 2'd0);
    assign read_enb_1   = w_rd & (r_port == 2'd1);
    assign read_enb_2   = w_rd & (r_port == 2'd2);
    assign soft_reset_0 = r_soft[0];
    assign soft_reset_1 = r_soft[1];
    assign soft_reset_2 = r_soft[2];
    assign out_port     = r_port;
    assign busy         = r_busy;

endmodule

// File: tb/tb_router_out_sched.sv
// Scoreboard bench for router_out_sched: FIFO models feed packets,
// expected egress bytes are queued at load time and matched on transfer.
module tb_router_out_sched;

    typedef struct packed {
        logic [1:0] port;
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       out_ready = 1'b0;
    logic [2:0] fe = 3'b111;
    logic [2:0] frc = 3'b000;
    logic [7:0] fd [3];

    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic [7:0] out_data;
    logic       out_valid, out_last, busy;
    logic [1:0] out_port;
    logic [2:0] w_rd, w_soft;

    exp_t       exp_q [$];
    logic [7:0] fq [3][$];
    int         errors = 0;
    int         checks = 0;
    int         n_out = 0;
    int         n_rd [3] = '{0, 0, 0};
    int         n_soft [3] = '{0, 0, 0};

    router_out_sched dut (
        .clock        (clock),
        .reset        (reset),
        .fifo_empty   (fe),
        .fifo_data_0  (fd[0]),
        .fifo_data_1  (fd[1]),
        .fifo_data_2  (fd[2]),
        .read_enb_0   (read_enb_0),
        .read_enb_1   (read_enb_1),
        .read_enb_2   (read_enb_2),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .out_port     (out_port),
        .busy         (busy)
    );

    assign w_rd   = {read_enb_2, read_enb_1, read_enb_0};
    assign w_soft = {soft_reset_2, soft_reset_1, soft_reset_0};

    always #5 clock = ~clock;

    // Router FIFO models: data one cycle after the read strobe.
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (w_soft[i]) begin
                fq[i].delete();
            end else if (w_rd[i] && fq[i].size() > 0) begin
                fd[i] <= fq[i].pop_front();
            end
            fe[i] <= (fq[i].size() == 0) || frc[i];
        end
    end

    always @(negedge clock) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (w_rd[i]) n_rd[i]++;
            if (w_soft[i]) n_soft[i]++;
        end
        if (out_valid && out_ready) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL egress_extra got port=%0d data=%02h last=%0d exp none",
                         out_port, out_data, out_last);
            end else begin
                e = exp_q.pop_front();
                if ({out_port, out_last, out_data} !== {e.port, e.last, e.data}) begin
                    errors++;
                    $display("FAIL egress_byte got port=%0d data=%02h last=%0d exp port=%0d data=%02h last=%0d",
                             out_port, out_data, out_last, e.port, e.data, e.last);
                end
            end
        end
    end

    task automatic load(input int p, input logic [1:0] a, input int len,
                        input logic [7:0] seed, input bit ex);
        logic [7:0] b;
        logic [7:0] par;
        exp_t       e;
        par = 8'h00;
        for (int i = 0; i <= len + 1; i++) begin
            if (i == 0) b = {6'(len), a};
            else if (i <= len) b = seed + 8'(i);
            else b = par;
            par = par ^ b;
            fq[p].push_back(b);
            if (ex) begin
                e.port = 2'(p);
                e.last = (i == len + 1);
                e.data = b;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input int lim, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < lim && !ok; c++) begin
            @(posedge clock); #1;
            if (exp_q.size() == 0 && !busy && !out_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_out(input int tgt);
        for (int c = 0; c < 80 && n_out < tgt; c++) begin
            @(posedge clock); #1;
        end
        checks++;
        if (n_out < tgt) begin
            errors++;
            $display("FAIL wait_out got=%0d exp>=%0d", n_out, tgt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({w_rd, w_soft, out_valid, out_last, busy} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0",
                     {w_rd, w_soft, out_valid, out_last, busy});
        end
        checks++;
        if ({out_port, out_data} !== 10'd0) begin
            errors++;
            $display("FAIL reset_data got port=%0d data=%02h exp 0", out_port, out_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int r0;
        out_ready = 1'b1;
        r0 = n_rd[0];
        load(0, 2'd0, 3, 8'hA0, 1'b1);
        wait_drain(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_drain got=timeout exp=done");
        end
        checks++;
        if (n_rd[0] - r0 != 5) begin
            errors++;
            $display("FAIL single_reads got=%0d exp=5", n_rd[0] - r0);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        load(1, 2'd1, 2, 8'h10, 1'b1);
        load(2, 2'd2, 1, 8'h20, 1'b1);
        load(0, 2'd0, 2, 8'h30, 1'b1);
        wait_drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_drain got=timeout exp=done left=%0d", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int r0, snap, s0;
        r0 = n_rd[1];
        s0 = n_soft[0] + n_soft[1] + n_soft[2];
        out_ready = 1'b1;
        load(1, 2'd1, 8, 8'h40, 1'b1);
        wait_out(n_out + 3);
        out_ready = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        snap = n_rd[1];
        repeat (7) begin @(posedge clock); #1; end
        checks++;
        if (n_rd[1] != snap || read_enb_1 !== 1'b0) begin
            errors++;
            $display("FAIL bp_reads got=%0d rd=%b exp=%0d rd=0", n_rd[1], read_enb_1, snap);
        end
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got valid=%b busy=%b exp 1 1", out_valid, busy);
        end
        out_ready = 1'b1;
        wait_drain(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_drain got=timeout exp=done");
        end
        checks++;
        if (n_rd[1] - r0 != 10) begin
            errors++;
            $display("FAIL bp_total_reads got=%0d exp=10", n_rd[1] - r0);
        end
        checks++;
        if (n_soft[0] + n_soft[1] + n_soft[2] != s0) begin
            errors++;
            $display("FAIL bp_soft got=%0d exp=%0d", n_soft[0] + n_soft[1] + n_soft[2], s0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        out_ready = 1'b0;
        load(2, 2'd2, 10, 8'h50, 1'b0);
        load(0, 2'd0, 1, 8'h60, 1'b1);
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge clock);
        k = 0;
        for (int c = 0; c < 60 && !soft_reset_2; c++) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (k != 30) begin
            errors++;
            $display("FAIL to_latency got=%0d exp=30", k);
        end
        checks++;
        if (soft_reset_2 !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_abort got soft=%b valid=%b busy=%b exp 1 0 0",
                     soft_reset_2, out_valid, busy);
        end
        @(posedge clock); #1;
        checks++;
        if (soft_reset_2 !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse_width got=%b exp=0", soft_reset_2);
        end
        out_ready = 1'b1;
        wait_drain(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_next_grant got=timeout exp=done");
        end
        checks++;
        if (n_soft[2] != 1 || n_soft[0] + n_soft[1] != 0) begin
            errors++;
            $display("FAIL to_soft_count got=%0d/%0d/%0d exp=0/0/1",
                     n_soft[0], n_soft[1], n_soft[2]);
        end
    endtask

    task automatic test_fifo_empty();
        bit ok;
        int r0, snap;
        out_ready = 1'b1;
        r0 = n_rd[0];
        load(0, 2'd3, 6, 8'h70, 1'b1);
        for (int c = 0; c < 60 && n_rd[0] - r0 < 3; c++) begin
            @(posedge clock); #1;
        end
        frc[0] = 1'b1;
        @(posedge clock); #1;
        snap = n_rd[0];
        repeat (3) begin @(posedge clock); #1; end
        checks++;
        if (n_rd[0] != snap || read_enb_0 !== 1'b0) begin
            errors++;
            $display("FAIL empty_stall got=%0d rd=%b exp=%0d rd=0", n_rd[0], read_enb_0, snap);
        end
        frc[0] = 1'b0;
        wait_drain(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL empty_drain got=timeout exp=done");
        end
        checks++;
        if (n_rd[0] - r0 != 8) begin
            errors++;
            $display("FAIL empty_reads got=%0d exp=8", n_rd[0] - r0);
        end
    endtask

    task automatic test_len0();
        bit ok;
        int r0, o0;
        out_ready = 1'b1;
        r0 = n_rd[1];
        o0 = n_out;
        load(1, 2'd1, 0, 8'h00, 1'b1);
        wait_drain(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL len0_drain got=timeout exp=done");
        end
        checks++;
        if (n_rd[1] - r0 != 2 || n_out - o0 != 2) begin
            errors++;
            $display("FAIL len0_count got rd=%0d out=%0d exp 2 2", n_rd[1] - r0, n_out - o0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b1;
        load(2, 2'd2, 12, 8'h80, 1'b1);
        wait_out(n_out + 2);
        reset = 1'b1;
        fq[2].delete();
        @(posedge clock); #1;
        checks++;
        if ({w_rd, w_soft, out_valid, out_last, busy, out_port, out_data} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_outs got=%h exp=0",
                     {w_rd, w_soft, out_valid, out_last, busy, out_port, out_data});
        end
        reset = 1'b0;
        exp_q.delete();
        load(0, 2'd0, 1, 8'h90, 1'b1);
        load(1, 2'd1, 2, 8'hB0, 1'b1);
        for (int c = 0; c < 20 && !busy; c++) begin
            @(posedge clock); #1;
        end
        checks++;
        if (busy !== 1'b1 || out_port !== 2'd0) begin
            errors++;
            $display("FAIL midreset_grant got busy=%b port=%0d exp 1 0", busy, out_port);
        end
        wait_drain(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset_drain got=timeout exp=done");
        end
    endtask

    initial begin
        fd[0] = 8'h00;
        fd[1] = 8'h00;
        fd[2] = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_fifo_empty();
        test_len0();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
